// File: rtl/fifo_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_controller
//  Description : Pointer, occupancy and flag sequencing for a 16 x 15-bit
//                FIFO wrapped around an external registered-read memory_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_controller #(
  parameter int DATA_WIDTH = 15,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] mem_wr_address,
  output logic [ADDR_WIDTH-1:0] mem_rd_address,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF_LVL = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_AE_LVL = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // Flags decode the registered count only, so they lag an accepted op by one cycle.
  assign w_full  = (count_q == C_DEPTH);
  assign w_empty = (count_q == '0);

  // A push into a full FIFO is allowed only when a pop frees a slot in the same cycle.
  assign w_do_pop  = pop & ~w_empty;
  assign w_do_push = push & (~w_full | w_do_pop);

  assign mem_wen        = w_do_push;
  assign mem_wr_address = wr_ptr_q;
  assign mem_data_in    = push_data;
  assign mem_ren        = w_do_pop;
  assign mem_rd_address = rd_ptr_q;

  assign pop_data     = mem_data_out;
  assign pop_valid    = pop_valid_q;
  assign count        = count_q;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (count_q >= C_AF_LVL);
  assign almost_empty = (count_q <= C_AE_LVL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(w_do_push);
    rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(w_do_pop);
    count_d     = count_q + (ADDR_WIDTH+1)'(w_do_push) - (ADDR_WIDTH+1)'(w_do_pop);
    pop_valid_d = w_do_pop;
    overflow_d  = overflow_q  | (push & ~w_do_push);
    underflow_d = underflow_q | (pop  & ~w_do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_controller
//  Description : Directed and random stimulus for fifo_controller against a
//                queue-based FIFO model and a registered-read memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_controller;

  logic        clock;
  logic        reset;
  logic        push;
  logic [14:0] push_data;
  logic        pop;
  logic [14:0] pop_data;
  logic        pop_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;
  logic [14:0] mem_data_in;
  logic [3:0]  mem_wr_address;
  logic [3:0]  mem_rd_address;
  logic        mem_wen;
  logic        mem_ren;
  logic [14:0] mem_data_out;

  fifo_controller #(
    .DATA_WIDTH(15),
    .ADDR_WIDTH(4),
    .AF_LEVEL  (14),
    .AE_LEVEL  (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .push          (push),
    .push_data     (push_data),
    .pop           (pop),
    .pop_data      (pop_data),
    .pop_valid     (pop_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow),
    .mem_data_in   (mem_data_in),
    .mem_wr_address(mem_wr_address),
    .mem_rd_address(mem_rd_address),
    .mem_wen       (mem_wen),
    .mem_ren       (mem_ren),
    .mem_data_out  (mem_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory_unit stand-in: synchronous write, registered read
  logic [14:0] mem [16];
  always @(posedge clock) begin
    if (mem_wen) mem[mem_wr_address] <= mem_data_in;
    if (mem_ren) mem_data_out <= mem[mem_rd_address];
  end

  int n_total = 0;
  int n_pass  = 0;

  logic [14:0] fq[$];
  int          wr_m, rd_m;
  bit          ovf_m, udf_m, pv_m;
  logic [14:0] pd_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    wr_m  = 0;
    rd_m  = 0;
    ovf_m = 0;
    udf_m = 0;
    pv_m  = 0;
  endtask

  task automatic step(input bit pp, input logic [14:0] dd, input bit pq);
    int          n;
    bit          dpop, dpush;
    logic [3:0]  diff;
    push      = pp;
    push_data = dd;
    pop       = pq;
    #1;
    n = fq.size();
    check("count",        32'(count),        32'(n));
    check("empty",        32'(empty),        32'(n == 0));
    check("full",         32'(full),         32'(n == 16));
    check("almost_full",  32'(almost_full),  32'(n >= 14));
    check("almost_empty", 32'(almost_empty), 32'(n <= 2));
    check("overflow",     32'(overflow),     32'(ovf_m));
    check("underflow",    32'(underflow),    32'(udf_m));
    check("pop_valid",    32'(pop_valid),    32'(pv_m));
    if (pv_m) check("pop_data", 32'(pop_data), 32'(pd_m));
    dpop  = pq && (n > 0);
    dpush = pp && ((n < 16) || dpop);
    check("mem_wen",        32'(mem_wen),        32'(dpush));
    check("mem_ren",        32'(mem_ren),        32'(dpop));
    check("mem_wr_address", 32'(mem_wr_address), 32'(wr_m));
    check("mem_rd_address", 32'(mem_rd_address), 32'(rd_m));
    if (dpush) check("mem_data_in", 32'(mem_data_in), 32'(dd));
    diff = mem_wr_address - mem_rd_address;
    check("ptr_invariant", 32'(diff), 32'(n % 16));
    @(posedge clock);
    pv_m = dpop;
    if (dpop)  pd_m = fq.pop_front();
    if (dpush) fq.push_back(dd);
    wr_m  = (wr_m + int'(dpush)) % 16;
    rd_m  = (rd_m + int'(dpop)) % 16;
    ovf_m = ovf_m | (pp && !dpush);
    udf_m = udf_m | (pq && !dpop);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    // idle after reset
    repeat (2) step(0, 0, 0);

    // three pushes then three pops
    step(1, 15'd10, 0);
    step(1, 15'd11, 0);
    step(1, 15'd12, 0);
    repeat (3) step(0, 0, 1);
    step(0, 0, 0);

    // fill to full, then one rejected push
    for (int i = 0; i < 16; i++) step(1, 15'(100 + i), 0);
    step(1, 15'd116, 0);
    step(0, 0, 0);

    // simultaneous push and pop while full, then drain
    step(1, 15'd200, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    step(0, 0, 0);

    // pops on empty, alone and with a push
    step(0, 0, 1);
    step(1, 15'd7, 1);
    step(0, 0, 1);
    step(0, 0, 0);

    // reset with an accepted pop in flight
    for (int i = 0; i < 5; i++) step(1, 15'(300 + i), 0);
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    step(0, 0, 0);
    step(0, 0, 0);

    // random traffic, push-heavy then pop-heavy then balanced
    for (int i = 0; i < 450; i++) begin
      int pw, rw;
      pw = (i < 150) ? 75 : (i < 300) ? 30 : 55;
      rw = (i < 150) ? 30 : (i < 300) ? 75 : 50;
      step($urandom_range(0, 99) < pw, 15'($urandom), $urandom_range(0, 99) < rw);
    end
    step(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
